// File: rtl/wavelet_store.sv
// wavelet_store: buffers lifting (low, high) pairs and writes them as two words into the frame memory.
// Define WAVELET_STORE_SAT_EN to clip written data to signed 12 bits and add the sticky sat_flag output.
module wavelet_store #(
  parameter int DATA_W     = 16,
  parameter int IMG_W      = 64,
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wavelet_mode,
  input  logic              transpose,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_low,
  input  logic [DATA_W-1:0] in_high,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
`ifdef WAVELET_STORE_SAT_EN
  output logic              sat_flag,
`endif
  output logic              busy,
  output logic              frame_done
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(IMG_W);
  typedef enum logic [1:0] {IDLE, WR_LO, WR_HI, DONE} state_t;
  state_t r_state, w_next;
  logic [DATA_W-1:0] r_lo [FIFO_DEPTH];
  logic [DATA_W-1:0] r_hi [FIFO_DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [PW:0] r_cnt;
  logic [CW-1:0] r_k, r_r, w_pm1, w_lm1;
  logic r_mode, r_tr;
  logic w_push, w_pop, w_last_k, w_last_r, w_start;
  logic [ADDR_W-1:0] w_col, w_addr;
  logic [DATA_W-1:0] w_raw;

  assign in_ready   = r_cnt != (PW+1)'(FIFO_DEPTH);
  assign w_push     = in_valid && in_ready;
  assign w_pop      = r_state == WR_HI && mem_ready;
  assign w_pm1      = r_mode ? CW'(IMG_W/4 - 1) : CW'(IMG_W/2 - 1);
  assign w_lm1      = r_mode ? CW'(IMG_W/2 - 1) : CW'(IMG_W - 1);
  assign w_last_k   = r_k == w_pm1;
  assign w_last_r   = r_r == w_lm1;
  // geometry is captured only when the first pair of a frame is taken
  assign w_start    = r_state == IDLE && r_cnt != '0 && r_k == '0 && r_r == '0;
  assign busy       = r_cnt != '0 || r_state != IDLE;
  assign frame_done = r_state == DONE;
  assign mem_we     = r_state == WR_LO || r_state == WR_HI;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  w_next = r_cnt != '0 ? WR_LO : IDLE;
      WR_LO: w_next = mem_ready ? WR_HI : WR_LO;
      WR_HI: w_next = !mem_ready ? WR_HI :
                      (w_last_k && w_last_r) ? DONE :
                      (r_cnt > (PW+1)'(1) || w_push) ? WR_LO : IDLE;
      DONE:  w_next = IDLE;
    endcase
  end

  // high band sits P columns (or P lines when transposed) after the low band
  assign w_col    = ADDR_W'(r_k) + (r_state == WR_HI ? ADDR_W'(w_pm1) + ADDR_W'(1) : '0);
  assign w_addr   = r_tr ? ADDR_W'(w_col * IMG_W) + ADDR_W'(r_r) : ADDR_W'(r_r * IMG_W) + w_col;
  assign mem_addr = mem_we ? w_addr : '0;
  assign w_raw    = r_state == WR_LO ? r_lo[r_rp] : r_state == WR_HI ? r_hi[r_rp] : '0;

`ifdef WAVELET_STORE_SAT_EN
  logic w_clip;
  assign w_clip    = !(&w_raw[DATA_W-1:11] || ~|w_raw[DATA_W-1:11]);
  assign mem_wdata = !w_clip ? w_raw :
                     w_raw[DATA_W-1] ? {{(DATA_W-11){1'b1}}, 11'h000} : {{(DATA_W-11){1'b0}}, 11'h7ff};
  always_ff @(posedge clk) begin
    if (rst || w_start) sat_flag <= 1'b0;
    else if (mem_we && mem_ready && w_clip) sat_flag <= 1'b1;
  end
`else
  assign mem_wdata = w_raw;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_k     <= '0;
      r_r     <= '0;
      r_mode  <= 1'b0;
      r_tr    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      if (w_start) {r_mode, r_tr} <= {wavelet_mode, transpose};
      if (w_pop) begin
        r_k <= w_last_k ? '0 : r_k + 1'b1;
        if (w_last_k) r_r <= w_last_r ? '0 : r_r + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_lo[r_wp] <= in_low;
      r_hi[r_wp] <= in_high;
    end
  end
endmodule
